disp_mux_pwm: RTL

- Parametrised N-digit 7-segment time-multiplexing driver; successor to the fixed 4-digit scanner.
- Adds per-digit enable, anti-ghosting blank interval, PWM brightness and a frame-start strobe.
- Sits between the digit-encoding logic and the board segment/anode pins.
- Segments and anodes are active-low.

---
 rtl/disp_pkg.sv | 56 +++++
 rtl/disp_slot_timer.sv | 61 ++++++
 rtl/disp_mux_pwm.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display driver.
// All segment encodings are active-low with bit 7 as the decimal point.
package disp_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_DP    = 8'h7F;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;

  // Hex nibble to active-low segment pattern, decimal point off.
  function automatic logic [7:0] seg_hex(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0:    s = SEG_0;
      4'h1:    s = SEG_1;
      4'h2:    s = SEG_2;
      4'h3:    s = SEG_3;
      4'h4:    s = SEG_4;
      4'h5:    s = SEG_5;
      4'h6:    s = SEG_6;
      4'h7:    s = SEG_7;
      4'h8:    s = SEG_8;
      4'h9:    s = SEG_9;
      4'hA:    s = SEG_A;
      4'hB:    s = SEG_B;
      4'hC:    s = SEG_C;
      4'hD:    s = SEG_D;
      4'hE:    s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

  // Clocks per digit slot: blank interval followed by the full PWM window.
  function automatic int unsigned slot_len(input int unsigned blank,
                                           input int unsigned bright_w);
    return blank + (32'd1 << bright_w);
  endfunction

endpackage

// File: rtl/disp_slot_timer.sv
// Slot counter and digit index for the display scanner; decodes blank/ON phase.
// With DISP_BLINK_EN a frame-end strobe is also provided for blink timing.
module disp_slot_timer
  import disp_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter int unsigned BRIGHT_W     = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  output logic                        slot_start_c_o,
  output logic                        blank_c_o,
  output logic [BRIGHT_W-1:0]         on_idx_c_o,
`ifdef DISP_BLINK_EN
  output logic                        frame_end_c_o,
`endif
  output logic [$clog2(N_DIGITS)-1:0] digit_o
);

  localparam int unsigned SLOT = slot_len(BLANK_CYCLES, BRIGHT_W);
  localparam int unsigned CW   = $clog2(SLOT);
  localparam int unsigned DW   = $clog2(N_DIGITS);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dig_q, dig_d;
  logic          slot_end;
  logic          last_digit;

  assign slot_end   = (cnt_q == CW'(SLOT - 1));
  assign last_digit = (dig_q == DW'(N_DIGITS - 1));

  // Explicit modulo wrap so non-power-of-two digit counts scan correctly.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    dig_d = dig_q;
    if (slot_end) begin
      cnt_d = '0;
      dig_d = last_digit ? '0 : dig_q + DW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      dig_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      dig_q <= dig_d;
    end
  end

  assign slot_start_c_o = (cnt_q == '0);
  assign blank_c_o      = (cnt_q < CW'(BLANK_CYCLES));
  assign on_idx_c_o     = BRIGHT_W'(cnt_q - CW'(BLANK_CYCLES));
  assign digit_o        = dig_q;
`ifdef DISP_BLINK_EN
  assign frame_end_c_o  = slot_end & last_digit;
`endif

endmodule

// File: rtl/disp_mux_pwm.sv
// N-digit active-low 7-segment multiplexer with blanking, PWM brightness and frame strobe.
// Define DISP_BLINK_EN to add the blinkMask input and frame-based blink phase.
module disp_mux_pwm
  import disp_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned BLANK_CYCLES = 2,
`ifdef DISP_BLINK_EN
  parameter int unsigned BLINK_FRAMES = 64,
`endif
  parameter int unsigned BRIGHT_W     = 3
) (
  input  logic                    ClkDisp,
  input  logic                    Reset,
  input  logic [8*N_DIGITS-1:0]   segIn,
  input  logic [N_DIGITS-1:0]     digitEn,
  input  logic [BRIGHT_W-1:0]     brightness,
`ifdef DISP_BLINK_EN
  input  logic [N_DIGITS-1:0]     blinkMask,
`endif
  output logic [7:0]              segOut,
  output logic [N_DIGITS-1:0]     anOut,
  output logic                    frameStart
);

  localparam int unsigned DW = $clog2(N_DIGITS);

  logic                slot_start;
  logic                blank;
  logic [BRIGHT_W-1:0] on_idx;
  logic [DW-1:0]       digit;

  logic [7:0]          cap_seg_q, cap_seg_d;
  logic                cap_en_q, cap_en_d;
  logic [BRIGHT_W-1:0] cap_bright_q, cap_bright_d;

  logic [7:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic                frame_q, frame_d;

  logic [7:0]          seg_sel;
  logic                en_sel;
  logic                lit;

`ifdef DISP_BLINK_EN
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic          frame_end;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          hidden_q, hidden_d;
`endif

  disp_slot_timer #(
    .N_DIGITS     (N_DIGITS),
    .BLANK_CYCLES (BLANK_CYCLES),
    .BRIGHT_W     (BRIGHT_W)
  ) u_timer (
    .clk_i          (ClkDisp),
    .rst_i          (Reset),
    .slot_start_c_o (slot_start),
    .blank_c_o      (blank),
    .on_idx_c_o     (on_idx),
`ifdef DISP_BLINK_EN
    .frame_end_c_o  (frame_end),
`endif
    .digit_o        (digit)
  );

  // Select the current digit's pattern and effective enable.
  always_comb begin
    seg_sel = SEG_BLANK;
    en_sel  = 1'b0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (digit == DW'(i)) begin
        seg_sel = segIn[8*i +: 8];
`ifdef DISP_BLINK_EN
        en_sel  = digitEn[i] & ~(hidden_q & blinkMask[i]);
`else
        en_sel  = digitEn[i];
`endif
      end
    end
  end

  // Inputs are sampled once at slot entry and held for the slot.
  always_comb begin
    cap_seg_d    = cap_seg_q;
    cap_en_d     = cap_en_q;
    cap_bright_d = cap_bright_q;
    if (slot_start) begin
      cap_seg_d    = seg_sel;
      cap_en_d     = en_sel;
      cap_bright_d = brightness;
    end
  end

  // Blank interval always dark; PWM compare gates the single active anode.
  always_comb begin
    lit     = ~blank & cap_en_q & (on_idx < cap_bright_q);
    seg_d   = lit ? cap_seg_q : SEG_BLANK;
    an_d    = '1;
    frame_d = slot_start & (digit == '0);
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (digit == DW'(i)) begin
        an_d[int'(N_DIGITS) - 1 - i] = ~lit;
      end
    end
  end

  always_ff @(posedge ClkDisp or posedge Reset) begin
    if (Reset) begin
      cap_seg_q    <= SEG_BLANK;
      cap_en_q     <= 1'b0;
      cap_bright_q <= '0;
      seg_q        <= SEG_BLANK;
      an_q         <= '1;
      frame_q      <= 1'b0;
    end else begin
      cap_seg_q    <= cap_seg_d;
      cap_en_q     <= cap_en_d;
      cap_bright_q <= cap_bright_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_q      <= frame_d;
    end
  end

`ifdef DISP_BLINK_EN
  // Phase flips at the end of every BLINK_FRAMES-th frame, ahead of the next capture.
  always_comb begin
    fcnt_d   = fcnt_q;
    hidden_d = hidden_q;
    if (frame_end) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d   = '0;
        hidden_d = ~hidden_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge ClkDisp or posedge Reset) begin
    if (Reset) begin
      fcnt_q   <= '0;
      hidden_q <= 1'b0;
    end else begin
      fcnt_q   <= fcnt_d;
      hidden_q <= hidden_d;
    end
  end
`endif

  assign segOut     = seg_q;
  assign anOut      = an_q;
  assign frameStart = frame_q;

endmodule
